// File: rtl/window_integrator.sv
// Integrates a signed per-cycle sample stream over a programmable window of nsamp cycles,
// starting lat cycles after a start trigger, and emits one full-precision sum with a strobe.
module window_integrator #(
  parameter int unsigned dw  = 18,
  parameter int unsigned cw  = 16,
  parameter int unsigned lat = 3,
  localparam int unsigned aw = dw + cw
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [dw-1:0] xin,
  input  logic          start,
  input  logic [cw-1:0] nsamp,
  input  logic          clr_missed,
  output logic [aw-1:0] sum,
  output logic          sum_valid,
  output logic          busy,
  output logic          missed
);

  typedef enum logic [1:0] {StIdle, StWait, StAccum} state_e;

  state_e        state_q, state_d;
  logic [cw-1:0] scnt_q, scnt_d;
  logic          first_q, first_d;
  logic [aw-1:0] acc_q, acc_d;
  logic [aw-1:0] sum_q, sum_d;
  logic          sum_valid_q, sum_valid_d;
  logic          missed_q, missed_d;
  logic [aw-1:0] xin_ext;
  logic          wait_done;
  logic          accept;

  assign xin_ext = {{cw{xin[dw-1]}}, xin};
  assign accept  = (state_q == StIdle) && start && (nsamp != '0);

  generate
    if (lat > 0) begin : g_wait
      localparam int unsigned dcw       = $clog2(lat + 1);
      localparam int unsigned wait_init = (lat >= 2) ? lat - 2 : 0;
      logic [dcw-1:0] dcnt_q, dcnt_d;

      // Loaded so that WAIT lasts lat-1 cycles; lat==1 bypasses WAIT entirely.
      always_comb begin
        dcnt_d = dcnt_q;
        if (accept) begin
          dcnt_d = dcw'(wait_init);
        end else if (state_q == StWait && dcnt_q != '0) begin
          dcnt_d = dcnt_q - 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          dcnt_q <= '0;
        end else begin
          dcnt_q <= dcnt_d;
        end
      end

      assign wait_done = (dcnt_q == '0);
    end else begin : g_nowait
      assign wait_done = 1'b1;
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    scnt_d      = scnt_q;
    first_d     = first_q;
    acc_d       = acc_q;
    sum_d       = sum_q;
    sum_valid_d = 1'b0;

    missed_d = missed_q;
    if (start && state_q != StIdle) begin
      missed_d = 1'b1;
    end else if (clr_missed) begin
      missed_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (lat == 0) begin
            // The sample coincident with start is the first one of the window.
            acc_d   = xin_ext;
            first_d = 1'b0;
            scnt_d  = nsamp - cw'(1);
            if (nsamp == cw'(1)) begin
              sum_d       = xin_ext;
              sum_valid_d = 1'b1;
            end else begin
              state_d = StAccum;
            end
          end else begin
            scnt_d  = nsamp;
            first_d = 1'b1;
            state_d = (lat == 1) ? StAccum : StWait;
          end
        end
      end
      StWait: begin
        if (wait_done) begin
          state_d = StAccum;
        end
      end
      StAccum: begin
        acc_d   = first_q ? xin_ext : acc_q + xin_ext;
        first_d = 1'b0;
        scnt_d  = scnt_q - cw'(1);
        if (scnt_q == cw'(1)) begin
          state_d     = StIdle;
          sum_d       = acc_d;
          sum_valid_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      scnt_q      <= '0;
      first_q     <= 1'b0;
      acc_q       <= '0;
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
      missed_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      scnt_q      <= scnt_d;
      first_q     <= first_d;
      acc_q       <= acc_d;
      sum_q       <= sum_d;
      sum_valid_q <= sum_valid_d;
      missed_q    <= missed_d;
    end
  end

  assign sum       = sum_q;
  assign sum_valid = sum_valid_q;
  assign busy      = (state_q != StIdle);
  assign missed    = missed_q;

endmodule

// File: tb/tb_window_integrator.sv
// Drives two window_integrator instances (lat=3 and lat=0) with shared stimulus and checks them
// against a window-level reference model through per-instance scoreboards.
module tb_window_integrator;

  localparam int unsigned DW = 18;
  localparam int unsigned CW = 8;
  localparam int unsigned AW = DW + CW;

  logic          clk        = 1'b0;
  logic          rst_n      = 1'b0;
  logic          start      = 1'b0;
  logic          clr_missed = 1'b0;
  logic [DW-1:0] xin        = '0;
  logic [CW-1:0] nsamp      = '0;
  logic [AW-1:0] sum0, sum1;
  logic          v0, v1, b0, b1, m0, m1;

  window_integrator #(.dw(DW), .cw(CW), .lat(3)) u_dut0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .xin        (xin),
    .start      (start),
    .nsamp      (nsamp),
    .clr_missed (clr_missed),
    .sum        (sum0),
    .sum_valid  (v0),
    .busy       (b0),
    .missed     (m0)
  );

  window_integrator #(.dw(DW), .cw(CW), .lat(0)) u_dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .xin        (xin),
    .start      (start),
    .nsamp      (nsamp),
    .clr_missed (clr_missed),
    .sum        (sum1),
    .sum_valid  (v1),
    .busy       (b1),
    .missed     (m1)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     cyc;
    longint sum;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit mon_en = 1'b0;

  // Reference model: one open window per instance, described by its accept cycle and length.
  int     latv [2] = '{3, 0};
  bit     w_act[2];
  int     w_t  [2];
  int     w_n  [2];
  longint w_acc[2];
  longint h_sum[2];
  bit     m_out[2];

  // Expected outputs for the current cycle, captured before this cycle's inputs are applied.
  bit     eb[2];
  bit     em[2];
  longint eh[2];

  function automatic bit busy_at(input int d, input int c);
    return w_act[d] && (c >= w_t[d] + 1) && (c <= w_t[d] + latv[d] + w_n[d] - 1);
  endfunction

  task automatic model_step(input int d, input bit r, input bit s, input int n, input bit c,
                            input longint x);
    exp_t e;
    bit   b;
    b = eb[d];
    if (!r) begin
      w_act[d] = 1'b0;
      m_out[d] = 1'b0;
      h_sum[d] = 0;
      return;
    end
    if (s && b) m_out[d] = 1'b1;
    else if (c) m_out[d] = 1'b0;
    if (s && n != 0 && !b) begin
      w_act[d] = 1'b1;
      w_t[d]   = cyc;
      w_n[d]   = n;
      w_acc[d] = 0;
    end
    if (w_act[d] && cyc >= w_t[d] + latv[d] && cyc <= w_t[d] + latv[d] + w_n[d] - 1) begin
      w_acc[d] += x;
      if (cyc == w_t[d] + latv[d] + w_n[d] - 1) begin
        e.cyc    = cyc + 1;
        e.sum    = w_acc[d];
        h_sum[d] = w_acc[d];
        w_act[d] = 1'b0;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
      end
    end
  endtask

  task automatic tick(input bit r, input bit s, input int n, input bit c, input longint x);
    @(posedge clk);
    #1;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      eb[d] = busy_at(d, cyc);
      em[d] = m_out[d];
      eh[d] = h_sum[d];
    end
    mon_en     = 1'b1;
    rst_n      = r;
    start      = s;
    nsamp      = CW'(n);
    clr_missed = c;
    xin        = DW'(x);
    for (int d = 0; d < 2; d++) model_step(d, r, s, n, c, longint'($signed(xin)));
  endtask

  task automatic check(input int d, input logic v, input logic [AW-1:0] s, input logic b,
                       input logic m);
    exp_t   e;
    bit     have;
    longint act;
    have = 1'b0;
    act  = longint'($signed(s));
    if (d == 0 && q0.size() > 0 && q0[0].cyc <= cyc) begin
      e = q0.pop_front(); have = 1'b1;
    end
    if (d == 1 && q1.size() > 0 && q1[0].cyc <= cyc) begin
      e = q1.pop_front(); have = 1'b1;
    end
    tests++;
    if (v !== have) begin
      fails++;
      $display("FAIL strobe dut%0d cyc %0d: sum_valid=%b expected %b", d, cyc, v, have);
    end
    if (have) begin
      tests++;
      if (act != e.sum || e.cyc != cyc) begin
        fails++;
        $display("FAIL window_sum dut%0d cyc %0d: sum=%0d expected %0d (due cyc %0d)",
                 d, cyc, act, e.sum, e.cyc);
      end
    end
    tests++;
    if (act != eh[d]) begin
      fails++;
      $display("FAIL sum_hold dut%0d cyc %0d: sum=%0d expected %0d", d, cyc, act, eh[d]);
    end
    tests++;
    if (b !== eb[d]) begin
      fails++;
      $display("FAIL busy dut%0d cyc %0d: busy=%b expected %b", d, cyc, b, eb[d]);
    end
    tests++;
    if (m !== em[d]) begin
      fails++;
      $display("FAIL missed dut%0d cyc %0d: missed=%b expected %b", d, cyc, m, em[d]);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check(0, v0, sum0, b0, m0);
      check(1, v1, sum1, b1, m1);
    end
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      w_act[d] = 1'b0; w_t[d] = 0; w_n[d] = 0; w_acc[d] = 0;
      h_sum[d] = 0; m_out[d] = 1'b0; eb[d] = 1'b0; em[d] = 1'b0; eh[d] = 0;
    end

    // Reset and idle with no start.
    repeat (5) tick(1'b0, 1'b0, 0, 1'b0, 0);
    repeat (6) tick(1'b1, 1'b0, 0, 1'b0, cyc + 1);

    // Basic window on a ramp.
    tick(1'b1, 1'b1, 4, 1'b0, cyc + 1);
    repeat (10) tick(1'b1, 1'b0, 0, 1'b0, cyc + 1);

    // Most negative sample over the longest window.
    tick(1'b1, 1'b1, 255, 1'b0, -131072);
    repeat (262) tick(1'b1, 1'b0, 0, 1'b0, -131072);

    // Back-to-back start in the strobe cycle, then a start while busy.
    tick(1'b1, 1'b1, 2, 1'b0, cyc + 1);
    repeat (4) tick(1'b1, 1'b0, 0, 1'b0, cyc + 1);
    tick(1'b1, 1'b1, 2, 1'b0, cyc + 1);
    tick(1'b1, 1'b1, 3, 1'b0, cyc + 1);
    repeat (8) tick(1'b1, 1'b0, 0, 1'b0, cyc + 1);
    tick(1'b1, 1'b0, 0, 1'b1, cyc + 1);
    repeat (3) tick(1'b1, 1'b0, 0, 1'b0, cyc + 1);

    // Clear and busy-start in the same cycle: set wins.
    tick(1'b1, 1'b1, 5, 1'b0, cyc + 1);
    tick(1'b1, 1'b1, 5, 1'b1, cyc + 1);
    repeat (10) tick(1'b1, 1'b0, 0, 1'b0, cyc + 1);
    tick(1'b1, 1'b0, 0, 1'b1, cyc + 1);

    // Zero-length start is ignored.
    tick(1'b1, 1'b1, 0, 1'b0, cyc + 1);
    repeat (5) tick(1'b1, 1'b0, 0, 1'b0, cyc + 1);

    // Reset in the middle of a long window, then a fresh window.
    tick(1'b1, 1'b1, 100, 1'b0, cyc + 1);
    repeat (19) tick(1'b1, 1'b0, 0, 1'b0, cyc + 1);
    repeat (2) tick(1'b0, 1'b0, 0, 1'b0, cyc + 1);
    repeat (3) tick(1'b1, 1'b0, 0, 1'b0, cyc + 1);
    tick(1'b1, 1'b1, 7, 1'b0, cyc + 1);
    repeat (12) tick(1'b1, 1'b0, 0, 1'b0, cyc + 1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bit     r, s, c;
      int     n;
      longint x;
      r = ($urandom_range(0, 199) != 0);
      s = ($urandom_range(0, 7) == 0);
      c = ($urandom_range(0, 29) == 0);
      n = ($urandom_range(0, 19) == 0) ? 255 : int'($urandom_range(0, 12));
      x = longint'($signed(DW'($urandom)));
      tick(r, s, n, c, x);
    end

    repeat (300) tick(1'b1, 1'b0, 0, 1'b0, longint'($signed(DW'($urandom))));

    @(posedge clk);
    @(negedge clk);
    #1;
    tests++;
    if (q0.size() != 0) begin
      fails++;
      $display("FAIL drain dut0: %0d pending sums, expected 0", q0.size());
    end
    tests++;
    if (q1.size() != 0) begin
      fails++;
      $display("FAIL drain dut1: %0d pending sums, expected 0", q1.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
